// File: rtl/dram_stream_loader.sv
// Host-side stream source and result sink for the accelerator: streams a preloaded word buffer, captures results.
// Optional LOADER_THROTTLE_EN adds a 'gap' port that inserts idle cycles after each streamed word.
module dram_stream_loader #(
    parameter int DATA_W = 32,
    parameter int SRC_AW = 12,
    parameter int RES_AW = 7
) (
    input  logic              clk,
    input  logic              rst,
`ifdef LOADER_THROTTLE_EN
    input  logic [3:0]        gap,
`endif
    input  logic              src_we,
    input  logic [SRC_AW-1:0] src_waddr,
    input  logic [DATA_W-1:0] src_wdata,
    input  logic [SRC_AW:0]   word_count,
    input  logic              start,
    output logic              acc_ready,
    output logic [DATA_W-1:0] acc_data,
    input  logic              acc_valid,
    input  logic [DATA_W-1:0] acc_ofmap,
    input  logic              acc_done,
    input  logic [RES_AW-1:0] res_raddr,
    output logic [DATA_W-1:0] res_rdata,
    output logic [RES_AW:0]   res_count,
    output logic              busy,
    output logic              finish,
    output logic              overflow,
    output logic              early_done
);

    localparam int SRC_DEPTH = 1 << SRC_AW;
    localparam int RES_DEPTH = 1 << RES_AW;
    localparam logic [SRC_AW:0] SRC_FULL = {1'b1, {SRC_AW{1'b0}}};
    localparam logic [SRC_AW:0] IDX_ZERO = {(SRC_AW+1){1'b0}};
    localparam logic [SRC_AW:0] IDX_ONE  = {{SRC_AW{1'b0}}, 1'b1};
    localparam logic [RES_AW:0] CNT_ZERO = {(RES_AW+1){1'b0}};
    localparam logic [RES_AW:0] CNT_ONE  = {{RES_AW{1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_STREAM   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    state_t              state_r;
    logic [SRC_AW:0]     idx_r;
    logic [SRC_AW:0]     wc_r;
    logic                acc_ready_r;
    logic [DATA_W-1:0]   acc_data_r;
    logic                busy_r;
    logic                finish_r;
    logic                overflow_r;
    logic                early_done_r;
    logic [RES_AW:0]     res_count_r;
    logic [DATA_W-1:0]   res_rdata_r;
    logic [DATA_W-1:0]   src_mem_r [SRC_DEPTH];
    logic [DATA_W-1:0]   res_mem_r [RES_DEPTH];
`ifdef LOADER_THROTTLE_EN
    logic [3:0]          gap_cfg_r;
    logic [3:0]          gap_cnt_r;
`endif

    logic                capture_s;
    logic                res_full_s;
    logic                res_we_s;
    logic                last_word_s;
    logic [SRC_AW:0]     wc_clamp_s;

    // Capture qualification, result-buffer full detection and word-count clamp.
    always_comb begin
        capture_s   = 1'b0;
        res_full_s  = res_count_r[RES_AW];
        res_we_s    = 1'b0;
        last_word_s = (idx_r == wc_r);
        wc_clamp_s  = word_count;
        if (((state_r == ST_STREAM) || (state_r == ST_DRAIN)) && acc_valid && !rst) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (capture_s && !res_full_s) begin
            res_we_s = 1'b1;
        end else begin
            res_we_s = 1'b0;
        end
        if (word_count > SRC_FULL) begin
            wc_clamp_s = SRC_FULL;
        end else begin
            wc_clamp_s = word_count;
        end
    end

    // Host writes to the source buffer are blocked for the whole run.
    always_ff @(posedge clk) begin
        if (src_we && !busy_r && !rst) begin
            src_mem_r[src_waddr] <= src_wdata;
        end
    end

    // Result buffer write port.
    always_ff @(posedge clk) begin
        if (res_we_s) begin
            res_mem_r[res_count_r[RES_AW-1:0]] <= acc_ofmap;
        end
    end

    // Result read port; a same-cycle capture is not forwarded, so old data is returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_rdata_r <= DATA_ZERO;
        end else begin
            res_rdata_r <= res_mem_r[res_raddr];
        end
    end

    // Run-control FSM with registered stream outputs and result counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            wc_r         <= IDX_ZERO;
            acc_ready_r  <= 1'b0;
            acc_data_r   <= DATA_ZERO;
            busy_r       <= 1'b0;
            finish_r     <= 1'b0;
            overflow_r   <= 1'b0;
            early_done_r <= 1'b0;
            res_count_r  <= CNT_ZERO;
`ifdef LOADER_THROTTLE_EN
            gap_cfg_r    <= 4'd0;
            gap_cnt_r    <= 4'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    finish_r <= 1'b0;
                    if (start) begin
                        busy_r       <= 1'b1;
                        res_count_r  <= CNT_ZERO;
                        overflow_r   <= 1'b0;
                        early_done_r <= 1'b0;
                        wc_r         <= wc_clamp_s;
                        idx_r        <= IDX_ZERO;
`ifdef LOADER_THROTTLE_EN
                        gap_cfg_r    <= gap;
                        gap_cnt_r    <= 4'd0;
`endif
                        if (word_count == IDX_ZERO) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_PREFETCH;
                        end
                    end
                end
                ST_PREFETCH: begin
                    acc_ready_r <= 1'b1;
                    acc_data_r  <= src_mem_r[0];
                    idx_r       <= IDX_ONE;
                    state_r     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (acc_done) begin
                        early_done_r <= 1'b1;
                        acc_ready_r  <= 1'b0;
                        acc_data_r   <= DATA_ZERO;
                        finish_r     <= 1'b1;
                        state_r      <= ST_FINISH;
                    end else if (acc_ready_r && last_word_s) begin
                        acc_ready_r <= 1'b0;
                        acc_data_r  <= DATA_ZERO;
                        state_r     <= ST_DRAIN;
`ifdef LOADER_THROTTLE_EN
                    end else if (acc_ready_r && (gap_cfg_r != 4'd0)) begin
                        acc_ready_r <= 1'b0;
                        gap_cnt_r   <= gap_cfg_r;
                    end else if (!acc_ready_r && (gap_cnt_r > 4'd1)) begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
`endif
                    end else begin
                        acc_ready_r <= 1'b1;
                        acc_data_r  <= src_mem_r[idx_r[SRC_AW-1:0]];
                        idx_r       <= idx_r + IDX_ONE;
                    end
                end
                ST_DRAIN: begin
                    acc_ready_r <= 1'b0;
                    acc_data_r  <= DATA_ZERO;
                    if (acc_done) begin
                        finish_r <= 1'b1;
                        state_r  <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    acc_ready_r <= 1'b0;
                    acc_data_r  <= DATA_ZERO;
                    finish_r    <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
            // Result counter saturates at full; further words are dropped and flagged.
            if (capture_s) begin
                if (res_full_s) begin
                    overflow_r <= 1'b1;
                end else begin
                    res_count_r <= res_count_r + CNT_ONE;
                end
            end
        end
    end

    assign acc_ready  = acc_ready_r;
    assign acc_data   = acc_data_r;
    assign res_rdata  = res_rdata_r;
    assign res_count  = res_count_r;
    assign busy       = busy_r;
    assign finish     = finish_r;
    assign overflow   = overflow_r;
    assign early_done = early_done_r;

endmodule

// File: tb/tb_dram_stream_loader.sv
// Directed self-checking bench for dram_stream_loader; the throttle scenario runs only with LOADER_THROTTLE_EN.
module tb_dram_stream_loader;

    localparam int DATA_W = 32;
    localparam int SRC_AW = 12;
    localparam int RES_AW = 7;

    logic              clk = 1'b0;
    logic              rst;
`ifdef LOADER_THROTTLE_EN
    logic [3:0]        gap;
`endif
    logic              src_we;
    logic [SRC_AW-1:0] src_waddr;
    logic [DATA_W-1:0] src_wdata;
    logic [SRC_AW:0]   word_count;
    logic              start;
    logic              acc_ready;
    logic [DATA_W-1:0] acc_data;
    logic              acc_valid;
    logic [DATA_W-1:0] acc_ofmap;
    logic              acc_done;
    logic [RES_AW-1:0] res_raddr;
    logic [DATA_W-1:0] res_rdata;
    logic [RES_AW:0]   res_count;
    logic              busy;
    logic              finish;
    logic              overflow;
    logic              early_done;

    int errors = 0;
    int checks = 0;
    int n_ready;

    always #5 clk = ~clk;

    dram_stream_loader #(.DATA_W(DATA_W), .SRC_AW(SRC_AW), .RES_AW(RES_AW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef LOADER_THROTTLE_EN
        .gap        (gap),
`endif
        .src_we     (src_we),
        .src_waddr  (src_waddr),
        .src_wdata  (src_wdata),
        .word_count (word_count),
        .start      (start),
        .acc_ready  (acc_ready),
        .acc_data   (acc_data),
        .acc_valid  (acc_valid),
        .acc_ofmap  (acc_ofmap),
        .acc_done   (acc_done),
        .res_raddr  (res_raddr),
        .res_rdata  (res_rdata),
        .res_count  (res_count),
        .busy       (busy),
        .finish     (finish),
        .overflow   (overflow),
        .early_done (early_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; src_we = 1'b0; src_waddr = '0; src_wdata = '0; word_count = '0;
        start = 1'b0; acc_valid = 1'b0; acc_ofmap = '0; acc_done = 1'b0; res_raddr = '0;
`ifdef LOADER_THROTTLE_EN
        gap = 4'd0;
`endif
        repeat (3) tick();
        check("rst_ready", acc_ready, 0);
        check("rst_data", acc_data, 0);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        check("rst_overflow", overflow, 0);
        check("rst_early", early_done, 0);
        check("rst_res_count", res_count, 0);
        check("rst_rdata", res_rdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            src_we = 1'b1; src_waddr = 12'(i); src_wdata = 32'(i + 1);
            tick();
        end
        src_we = 1'b0;

        // Four-word stream, results 7 (during stream) and 9 (during drain)
        word_count = 13'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_prefetch_ready", acc_ready, 0);
        check("t1_busy", busy, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t1_ready", acc_ready, 1);
            check("t1_data", acc_data, 32'(k + 1));
            acc_valid = (k == 2); acc_ofmap = 32'd7;
            tick();
        end
        acc_valid = 1'b0;
        check("t1_drain_ready", acc_ready, 0);
        check("t1_drain_data", acc_data, 0);
        check("t1_cnt1", res_count, 1);
        acc_valid = 1'b1; acc_ofmap = 32'd9;
        src_we = 1'b1; src_waddr = 12'd0; src_wdata = 32'd99;
        tick();
        acc_valid = 1'b0; src_we = 1'b0;
        check("t1_cnt2", res_count, 2);
        check("t1_no_finish_yet", finish, 0);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        check("t1_finish", finish, 1);
        check("t1_busy_fin", busy, 1);
        tick();
        check("t1_finish_once", finish, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_res_count", res_count, 2);
        check("t1_overflow", overflow, 0);
        check("t1_early", early_done, 0);
        res_raddr = 7'd0;
        tick();
        check("t1_res0", res_rdata, 7);
        res_raddr = 7'd1;
        tick();
        check("t1_res1", res_rdata, 9);
        acc_done = 1'b1; acc_valid = 1'b1;
        tick();
        acc_done = 1'b0; acc_valid = 1'b0;
        check("idle_done_finish", finish, 0);
        check("idle_done_busy", busy, 0);
        check("idle_valid_cnt", res_count, 2);

        // Zero-length run with 129 results: overflow and saturation
        word_count = 13'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_busy", busy, 1);
        check("t2_cnt_clear", res_count, 0);
        check("t2_ready", acc_ready, 0);
        for (int i = 0; i < 129; i++) begin
            acc_valid = 1'b1; acc_ofmap = 32'(100 + i);
            tick();
        end
        acc_valid = 1'b0;
        check("t2_cnt_sat", res_count, 128);
        check("t2_overflow", overflow, 1);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        check("t2_finish", finish, 1);
        tick();
        check("t2_idle_busy", busy, 0);
        check("t2_overflow_sticky", overflow, 1);
        res_raddr = 7'd127;
        tick();
        check("t2_res127", res_rdata, 227);
        res_raddr = 7'd0;
        tick();
        check("t2_res0", res_rdata, 100);

        // Early done after the third of eight words; src[0] must still be 1
        word_count = 13'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_overflow_clear", overflow, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            check("t3_ready", acc_ready, 1);
            check("t3_data", acc_data, 32'(k + 1));
            acc_done = (k == 2);
            tick();
        end
        acc_done = 1'b0;
        check("t3_ready_stop", acc_ready, 0);
        check("t3_early", early_done, 1);
        check("t3_finish", finish, 1);
        tick();
        check("t3_idle_busy", busy, 0);
        check("t3_finish_once", finish, 0);
        check("t3_early_sticky", early_done, 1);

        // Reset in the middle of streaming, then a fresh two-word run
        word_count = 13'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_early_clear", early_done, 0);
        tick();
        check("t4_data0", acc_data, 1);
        acc_valid = 1'b1; acc_ofmap = 32'd55;
        tick();
        acc_valid = 1'b0;
        check("t4_data1", acc_data, 2);
        check("t4_cnt", res_count, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_ready", acc_ready, 0);
        check("t4_rst_data", acc_data, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_cnt", res_count, 0);
        word_count = 13'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_prefetch", acc_ready, 0);
        tick();
        check("t4_w0_ready", acc_ready, 1);
        check("t4_w0_data", acc_data, 1);
        tick();
        check("t4_w1_ready", acc_ready, 1);
        check("t4_w1_data", acc_data, 2);
        tick();
        check("t4_drain", acc_ready, 0);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        check("t4_finish", finish, 1);
        tick();
        check("t4_idle_busy", busy, 0);

`ifdef LOADER_THROTTLE_EN
        begin
            logic [2:0] exp_rdy [7];
            logic [31:0] exp_dat [7];
            exp_rdy = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1};
            exp_dat = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3};
            word_count = 13'd3; gap = 4'd2; start = 1'b1;
            tick();
            start = 1'b0; gap = 4'd0;
            tick();
            for (int k = 0; k < 7; k++) begin
                check("thr_ready", acc_ready, 32'(exp_rdy[k]));
                check("thr_data", acc_data, exp_dat[k]);
                tick();
            end
            check("thr_drain", acc_ready, 0);
            acc_done = 1'b1;
            tick();
            acc_done = 1'b0;
            check("thr_finish", finish, 1);
            check("thr_early", early_done, 0);
            tick();
        end
`endif

        // Oversized word_count is clamped to the buffer depth
        word_count = 13'd5000; start = 1'b1;
        tick();
        start = 1'b0;
        n_ready = 0;
        for (int c = 0; c < 6000; c++) begin
            tick();
            if (acc_ready) begin
                n_ready++;
            end else if (n_ready != 0) begin
                break;
            end
        end
        check("clamp_ready_cycles", n_ready, 4096);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        check("clamp_finish", finish, 1);
        tick();
        check("clamp_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
